// File: rtl/mem_sram_pkg.sv
// Shared types and constants for the SRAM controller and its storage bank.
// Response entries carry the widest legal data width; narrower users zero-extend.
package mem_sram_pkg;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;
    localparam int MAX_DATA_WIDTH   = 64;

    typedef struct packed {
        logic                      valid;
        logic [MAX_DATA_WIDTH-1:0] data;
    } resp_t;

    function automatic int clamp_latency(int lat);
        if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
        if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Single-port byte-enabled SRAM bank with a registered read port.
// Contents are intentionally never reset.
module mem_sram_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    en,
    input  logic                    we,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// SRAM controller: handshake, address decode, error counter and
// fixed-latency in-order response pipeline around one storage bank.
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter int LOCAL_MEM_ADDR_WIDTH = 32,
    parameter int LOCAL_MEM_DATA_WIDTH = 32,
    parameter int DEPTH_WORDS          = 1024,
    parameter int READ_LATENCY         = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              s_mem_req,
    output logic                              s_mem_gnt,
    input  logic [LOCAL_MEM_ADDR_WIDTH-1:0]   s_mem_addr,
    input  logic                              s_mem_we,
    input  logic [LOCAL_MEM_DATA_WIDTH-1:0]   s_mem_wdata,
    input  logic [LOCAL_MEM_DATA_WIDTH/8-1:0] s_mem_be,
    output logic                              s_mem_rvalid,
    output logic [LOCAL_MEM_DATA_WIDTH-1:0]   s_mem_rdata,
    output logic                              busy_o,
    output logic [15:0]                       err_cnt_o
);

    localparam int AW    = LOCAL_MEM_ADDR_WIDTH;
    localparam int DW    = LOCAL_MEM_DATA_WIDTH;
    localparam int OFF_W = $clog2(DW / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT   = clamp_latency(READ_LATENCY);
    localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(DEPTH_WORDS * (DW / 8));

    logic             hs;
    logic             in_range;
    logic             bank_en;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    bank_rdata;
    logic             v0_q;
    logic             rd_ok_q;
    logic [15:0]      err_cnt_q;
    logic             pipe_busy;
    logic             unused_hi;
    resp_t            head;
    resp_t            tail;

    assign hs        = s_mem_req & ~rst_i;
    assign s_mem_gnt = hs;
    assign in_range  = {1'b0, s_mem_addr} < ADDR_LIMIT;
    assign idx       = s_mem_addr[OFF_W +: IDX_W];
    assign bank_en   = hs & in_range;

    mem_sram_bank #(
        .DATA_WIDTH  (DW),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk_i (clk_i),
        .en    (bank_en),
        .we    (s_mem_we),
        .addr  (idx),
        .wdata (s_mem_wdata),
        .be    (s_mem_be),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v0_q      <= 1'b0;
            rd_ok_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            v0_q    <= hs;
            rd_ok_q <= bank_en & ~s_mem_we;
            if (hs && !in_range && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // The bank output register is the first pipeline stage; writes and
    // out-of-range reads are masked to zero here.
    assign head = '{
        valid: v0_q,
        data:  rd_ok_q ? MAX_DATA_WIDTH'(bank_rdata) : '0
    };

    if (LAT == 1) begin : g_lat1
        assign tail      = head;
        assign pipe_busy = 1'b0;
    end else begin : g_pipe
        resp_t pipe_q [LAT-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < LAT - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= head;
                for (int i = 1; i < LAT - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        always_comb begin
            pipe_busy = 1'b0;
            for (int i = 0; i < LAT - 1; i++) begin
                pipe_busy = pipe_busy | pipe_q[i].valid;
            end
        end

        assign tail = pipe_q[LAT-2];
    end

    assign s_mem_rvalid = tail.valid;
    assign s_mem_rdata  = tail.data[DW-1:0];
    assign busy_o       = hs | v0_q | pipe_busy;
    assign err_cnt_o    = err_cnt_q;
    assign unused_hi    = ^tail.data;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl at READ_LATENCY 1, 2 and 4 in parallel.
// Each request carries its hand-computed response, due LAT cycles later.
module tb_mem_sram_ctrl;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic        gnt  [N];
    logic        rv   [N];
    logic [31:0] rd   [N];
    logic        busy [N];
    logic [15:0] ec   [N];

    bit          ev [N][0:511];
    logic [31:0] ed [N][0:511];
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    logic [15:0] exp_err = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_sram_ctrl #(
            .READ_LATENCY (g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst_i),
            .s_mem_req    (req),
            .s_mem_gnt    (gnt[g]),
            .s_mem_addr   (addr),
            .s_mem_we     (we),
            .s_mem_wdata  (wdata),
            .s_mem_be     (be),
            .s_mem_rvalid (rv[g]),
            .s_mem_rdata  (rd[g]),
            .busy_o       (busy[g]),
            .err_cnt_o    (ec[g])
        );
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] exp, input logic rs);
        logic bexp;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("L%0d rvalid c%0d", lat_of(k), cyc),
                32'(rv[k]), 32'(ev[k][cyc]));
            if (ev[k][cyc]) begin
                chk($sformatf("L%0d rdata c%0d", lat_of(k), cyc),
                    rd[k], ed[k][cyc]);
            end
            chk($sformatf("L%0d err_cnt c%0d", lat_of(k), cyc),
                32'(ec[k]), 32'(exp_err));
        end
        rst_i = rs;
        req   = r;
        we    = w;
        addr  = a;
        wdata = wd;
        be    = b;
        if (rs) begin
            exp_err = '0;
            for (int k = 0; k < N; k++) begin
                for (int j = cyc; j < cyc + 8; j++) ev[k][j] = 1'b0;
            end
        end else if (r) begin
            for (int k = 0; k < N; k++) begin
                ev[k][cyc + lat_of(k)] = 1'b1;
                ed[k][cyc + lat_of(k)] = exp;
            end
            if (a >= 32'h1000 && exp_err != 16'hFFFF) exp_err++;
        end
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("L%0d gnt c%0d", lat_of(k), cyc),
                32'(gnt[k]), 32'(r & ~rs));
            bexp = r & ~rs;
            for (int j = cyc; j < cyc + lat_of(k); j++) bexp |= ev[k][j];
            chk($sformatf("L%0d busy c%0d", lat_of(k), cyc),
                32'(busy[k]), 32'(bexp));
            if (rs) begin
                chk($sformatf("L%0d rst rvalid c%0d", lat_of(k), cyc),
                    32'(rv[k]), 32'd0);
                chk($sformatf("L%0d rst rdata c%0d", lat_of(k), cyc),
                    rd[k], 32'd0);
                chk($sformatf("L%0d rst err c%0d", lat_of(k), cyc),
                    32'(ec[k]), 32'd0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset holds grant low even with a request pending
        step(1, 0, 32'h0, 0, 4'h0, 0, 1);
        step(1, 0, 32'h0, 0, 4'h0, 0, 1);
        idle(2);

        step(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        step(1, 0, 32'h10, 0, 4'h0, 32'hDEADBEEF, 0);
        idle(5);

        step(1, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0);
        step(1, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 0);
        step(1, 0, 32'h20, 0, 4'h0, 32'h11BB33DD, 0);
        idle(5);

        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 32'h0, 0);
        end
        idle(5);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 32'(i * 4), 0, 4'h0, 32'h1000_0000 + 32'(i), 0);
        end
        idle(6);

        step(1, 1, 32'hFFC, 32'h12345678, 4'hF, 32'h0, 0);
        step(1, 0, 32'hFFC, 0, 4'h0, 32'h12345678, 0);
        step(1, 1, 32'h1000, 32'h5, 4'hF, 32'h0, 0);
        step(1, 0, 32'h1000, 0, 4'h0, 32'h0, 0);
        step(1, 0, 32'h0, 0, 4'h0, 32'h1000_0000, 0);
        step(1, 0, 32'hFFC, 0, 4'h0, 32'h12345678, 0);
        idle(6);

        step(1, 0, 32'h0, 0, 4'h0, 32'h1000_0000, 0);
        step(1, 0, 32'h4, 0, 4'h0, 32'h1000_0001, 0);
        step(1, 0, 32'h8, 0, 4'h0, 32'h1000_0002, 0);
        step(0, 0, 32'h0, 0, 4'h0, 32'h0, 1);
        idle(6);

        step(1, 0, 32'h10, 0, 4'h0, 32'h1000_0004, 0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
